// File: rtl/nway_cache.sv
// rtl/nway_cache.sv - n-way set-associative write-back cache with tree-PLRU replacement
module nway_cache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  localparam int s_line  = 8 * (2 ** s_offset)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       mem_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_byte_enable,
  output logic [31:0]       mem_rdata,
  output logic              mem_resp,
  output logic [31:0]       pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int s_tag    = 32 - s_index - s_offset;
  localparam int num_sets = 2 ** s_index;
  localparam int s_way    = $clog2(num_ways);
  localparam int s_word   = s_offset - 2;

  typedef enum logic [1:0] {CHECK, WRITE_BACK, ALLOCATE} state_e;

  state_e            state_q, state_d;
  logic [s_way-1:0]  victim_q, victim_d;

  logic [num_ways-1:0] valid_q [num_sets];
  logic [num_ways-1:0] dirty_q [num_sets];
  logic [num_ways-2:0] plru_q  [num_sets];
  logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
  logic [s_line-1:0]   line_q  [num_sets][num_ways];

  logic [s_tag-1:0]    tag;
  logic [s_index-1:0]  idx;
  logic [s_word-1:0]   word;
  logic                hit;
  logic [s_way-1:0]    hit_way;
  logic [s_way-1:0]    victim;
  logic [num_ways-2:0] plru_hit;
  logic [31:0]         wr_word;
  logic                wr_hit;
  logic                fill;
  logic                unused_addr_bits;

  assign tag  = mem_addr[31:s_index+s_offset];
  assign idx  = mem_addr[s_index+s_offset-1:s_offset];
  assign word = mem_addr[s_offset-1:2];
  assign unused_addr_bits = ^mem_addr[1:0];

  assign wr_hit = mem_resp && mem_write;
  assign fill   = (state_q == ALLOCATE) && pmem_resp;

  // Tag lookup across all ways of the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = s_way'(w);
      end
    end
  end

  // Victim choice: lowest invalid way, else walk the PLRU tree
  always_comb begin
    int vnode;
    logic             has_inv;
    logic [s_way-1:0] inv_way;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        has_inv = 1'b1;
        inv_way = s_way'(w);
      end
    end
    vnode = 0;
    for (int l = 0; l < s_way; l++) begin
      vnode = 2 * vnode + 1 + (plru_q[idx][vnode] ? 1 : 0);
    end
    victim = has_inv ? inv_way : s_way'(vnode - (num_ways - 1));
  end

  // PLRU bits after a hit: every node on the hit path points away from the hit way
  always_comb begin
    int hnode;
    plru_hit = plru_q[idx];
    hnode    = 0;
    for (int l = 0; l < s_way; l++) begin
      plru_hit[hnode] = ~hit_way[s_way-1-l];
      hnode = 2 * hnode + 1 + (hit_way[s_way-1-l] ? 1 : 0);
    end
  end

  // Byte-enable merge of the write data into the currently stored word
  always_comb begin
    wr_word = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (mem_byte_enable[i]) wr_word[8*i +: 8] = mem_wdata[8*i +: 8];
    end
  end

  // State register, victim hold and per-set metadata
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CHECK;
      victim_q <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (mem_resp) plru_q[idx] <= plru_hit;
      if (wr_hit) dirty_q[idx][hit_way] <= 1'b1;
      if (fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Line and tag storage; suppressed while reset is high so an aborted fill leaves no trace
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wr_hit) line_q[idx][hit_way][32*word +: 32] <= wr_word;
      if (fill) begin
        line_q[idx][victim_q] <= pmem_rdata;
        tag_q[idx][victim_q]  <= tag;
      end
    end
  end

  // Next-state logic; the victim is frozen once the miss leaves CHECK
  always_comb begin
    state_d  = state_q;
    victim_d = (state_q == CHECK) ? victim : victim_q;
    case (state_q)
      CHECK: begin
        if ((mem_read || mem_write) && !hit) begin
          state_d = dirty_q[idx][victim] ? WRITE_BACK : ALLOCATE;
        end
      end
      WRITE_BACK: if (pmem_resp) state_d = ALLOCATE;
      ALLOCATE:   if (pmem_resp) state_d = CHECK;
      default:    state_d = CHECK;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    logic [s_line-1:0] hit_line;
    hit_line   = line_q[idx][hit_way];
    mem_rdata  = hit_line[32*word +: 32];
    mem_resp   = (state_q == CHECK) && hit && (mem_read || mem_write);
    pmem_read  = (state_q == ALLOCATE);
    pmem_write = (state_q == WRITE_BACK);
    pmem_wdata = line_q[idx][victim_q];
    if (state_q == WRITE_BACK) begin
      pmem_addr = {tag_q[idx][victim_q], idx, {s_offset{1'b0}}};
    end else begin
      pmem_addr = {mem_addr[31:s_offset], {s_offset{1'b0}}};
    end
  end

endmodule

// File: tb/tb_nway_cache.sv
// tb/tb_nway_cache.sv - directed table-driven bench for nway_cache
module tb_nway_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_addr;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nway_cache #(.s_offset(5), .s_index(3), .num_ways(4)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        miss;
    logic        wb;
    logic [31:0] wb_addr;
    logic [63:0] wb_lo;
    logic        chk_rd;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory fill pattern: each word holds its own address tagged with 0xC in the top nibble
  function automatic logic [255:0] mkline(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    base = {a[31:5], 5'b0};
    for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'hC000_0000 | (base + 32'(4 * i));
    return l;
  endfunction

  task automatic add(input logic [31:0] addr, input logic rd, input logic wr,
                     input logic [31:0] wdata, input logic [3:0] be, input logic miss,
                     input logic wb, input logic [31:0] wb_addr, input logic [63:0] wb_lo,
                     input logic chk_rd, input logic [31:0] rdata);
    vec_t v;
    v.addr = addr; v.rd = rd; v.wr = wr; v.wdata = wdata; v.be = be; v.miss = miss;
    v.wb = wb; v.wb_addr = wb_addr; v.wb_lo = wb_lo; v.chk_rd = chk_rd; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  task automatic rd(input logic [31:0] addr, input logic miss, input logic [31:0] rdata);
    add(addr, 1'b1, 1'b0, 32'h0, 4'h0, miss, 1'b0, 32'h0, 64'h0, 1'b1, rdata);
  endtask

  initial begin
    logic [255:0] line;
    vec_t v;

    reset = 1'b1; mem_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata = '0; mem_byte_enable = '0; pmem_rdata = '0; pmem_resp = 1'b0;

    // write-hit merge, read+write, then set 0 PLRU variant (re-read way 0 before overflow)
    add(32'h44, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0011, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0);
    rd(32'h44, 1'b0, 32'h1122_CCDD);
    add(32'h44, 1'b1, 1'b1, 32'h5566_7788, 4'b1100, 1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 32'h1122_CCDD);
    rd(32'h44, 1'b0, 32'h5566_CCDD);
    rd(32'h000, 1'b1, 32'hC000_0000);
    rd(32'h104, 1'b1, 32'hC000_0104);
    rd(32'h208, 1'b1, 32'hC000_0208);
    rd(32'h30C, 1'b1, 32'hC000_030C);
    rd(32'h000, 1'b0, 32'hC000_0000);
    rd(32'h400, 1'b1, 32'hC000_0400);
    rd(32'h200, 1'b1, 32'hC000_0200);
    rd(32'h000, 1'b0, 32'hC000_0000);
    // set 1: plain fill order, overflow evicts way 0
    rd(32'h020, 1'b1, 32'hC000_0020);
    rd(32'h120, 1'b1, 32'hC000_0120);
    rd(32'h220, 1'b1, 32'hC000_0220);
    rd(32'h320, 1'b1, 32'hC000_0320);
    rd(32'h420, 1'b1, 32'hC000_0420);
    rd(32'h120, 1'b0, 32'hC000_0120);
    rd(32'h020, 1'b1, 32'hC000_0020);
    // set 3: dirty way 0 forced out through write-back
    rd(32'h060, 1'b1, 32'hC000_0060);
    rd(32'h164, 1'b1, 32'hC000_0164);
    rd(32'h268, 1'b1, 32'hC000_0268);
    rd(32'h36C, 1'b1, 32'hC000_036C);
    add(32'h060, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 32'h0);
    rd(32'h164, 1'b0, 32'hC000_0164);
    rd(32'h268, 1'b0, 32'hC000_0268);
    add(32'h460, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h060, {32'hC000_0064, 32'hDEAD_BEEF}, 1'b1, 32'hC000_0460);
    rd(32'h36C, 1'b0, 32'hC000_036C);

    step(); step();
    chk("reset pmem_read", 64'(pmem_read), 64'h0);
    chk("reset pmem_write", 64'(pmem_write), 64'h0);
    chk("reset mem_resp", 64'(mem_resp), 64'h0);
    reset = 1'b0;
    step();
    chk("idle pmem_read", 64'(pmem_read), 64'h0);
    chk("idle mem_resp", 64'(mem_resp), 64'h0);

    // cold read miss of 0x44 with a stalled memory
    mem_addr = 32'h44; mem_read = 1'b1;
    #1;
    chk("cold resp", 64'(mem_resp), 64'h0);
    step();
    chk("cold pmem_read", 64'(pmem_read), 64'h1);
    chk("cold pmem_addr", 64'(pmem_addr), 64'h40);
    step();
    chk("cold pmem_read held", 64'(pmem_read), 64'h1);
    chk("cold resp stall", 64'(mem_resp), 64'h0);
    line = '0;
    line[63:32] = 32'h1122_3344;
    pmem_rdata = line; pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    chk("cold hit resp", 64'(mem_resp), 64'h1);
    chk("cold hit rdata", 64'(mem_rdata), 64'h1122_3344);
    chk("cold pmem_read off", 64'(pmem_read), 64'h0);
    step();
    mem_read = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      mem_addr = v.addr; mem_read = v.rd; mem_write = v.wr;
      mem_wdata = v.wdata; mem_byte_enable = v.be;
      #1;
      if (v.miss) begin
        chk($sformatf("v%0d miss resp", k), 64'(mem_resp), 64'h0);
        step();
        if (v.wb) begin
          chk($sformatf("v%0d wb pmem_write", k), 64'(pmem_write), 64'h1);
          chk($sformatf("v%0d wb pmem_read", k), 64'(pmem_read), 64'h0);
          chk($sformatf("v%0d wb addr", k), 64'(pmem_addr), 64'(v.wb_addr));
          chk($sformatf("v%0d wb data", k), pmem_wdata[63:0], v.wb_lo);
          step();
          chk($sformatf("v%0d wb held", k), 64'(pmem_write), 64'h1);
          pmem_resp = 1'b1;
          step();
          pmem_resp = 1'b0;
        end
        chk($sformatf("v%0d alloc pmem_read", k), 64'(pmem_read), 64'h1);
        chk($sformatf("v%0d alloc pmem_write", k), 64'(pmem_write), 64'h0);
        chk($sformatf("v%0d alloc addr", k), 64'(pmem_addr), 64'({v.addr[31:5], 5'b0}));
        chk($sformatf("v%0d alloc resp", k), 64'(mem_resp), 64'h0);
        pmem_rdata = mkline(v.addr); pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
      end
      chk($sformatf("v%0d resp", k), 64'(mem_resp), 64'h1);
      chk($sformatf("v%0d no pmem", k), {62'h0, pmem_read, pmem_write}, 64'h0);
      if (v.chk_rd) chk($sformatf("v%0d rdata", k), 64'(mem_rdata), 64'(v.rdata));
      step();
      mem_read = 1'b0; mem_write = 1'b0;
    end

    // reset coincident with pmem_resp in ALLOCATE must abandon the fill
    mem_addr = 32'hA0; mem_read = 1'b1;
    #1;
    chk("abort miss resp", 64'(mem_resp), 64'h0);
    step();
    chk("abort pmem_read", 64'(pmem_read), 64'h1);
    reset = 1'b1; pmem_resp = 1'b1; pmem_rdata = mkline(32'hA0);
    step();
    reset = 1'b0; pmem_resp = 1'b0;
    chk("abort pmem_read off", 64'(pmem_read), 64'h0);
    chk("abort pmem_write off", 64'(pmem_write), 64'h0);
    chk("abort still miss", 64'(mem_resp), 64'h0);
    step();
    chk("abort refetch", 64'(pmem_read), 64'h1);
    chk("abort refetch addr", 64'(pmem_addr), 64'hA0);
    pmem_resp = 1'b1;
    step();
    pmem_resp = 1'b0;
    chk("abort refill resp", 64'(mem_resp), 64'h1);
    chk("abort refill rdata", 64'(mem_rdata), 64'hC000_00A0);
    step();
    mem_addr = 32'h44;
    #1;
    chk("reset cleared valid", 64'(mem_resp), 64'h0);
    mem_read = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
